// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared defaults, FSM state encoding and timing-parameter limits for spi_master
package spi_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_HALF     = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_CS_IDLE  = 4;

    localparam int MIN_HALF     = 2;
    localparam int MIN_CS_SETUP = 1;
    localparam int MIN_CS_HOLD  = 1;
    localparam int MIN_CS_IDLE  = 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_SCK_LO = 3'd2;
    localparam logic [2:0] ST_SCK_HI = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    function automatic int clamp_min(input int val, input int min_val);
        return (val < min_val) ? min_val : val;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_tick_timer.sv
// rtl/spi_tick_timer.sv - loadable down-counter with zero flag; times every spi_master phase
module spi_tick_timer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master, one DATA_W-bit word per CS frame, MSB first
// SPI_MASTER_BURST_EN: accept i_start in the o_done cycle and keep CS low across frames
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int HALF     = DEF_HALF,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_IDLE  = DEF_CS_IDLE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_cs,
    output logic              o_sclk,
    output logic              o_mosi,
    input  logic              i_miso
);

    localparam int HALF_E  = clamp_min(HALF, MIN_HALF);
    localparam int SETUP_E = clamp_min(CS_SETUP, MIN_CS_SETUP);
    localparam int HOLD_E  = clamp_min(CS_HOLD, MIN_CS_HOLD);
    localparam int IDLE_E  = clamp_min(CS_IDLE, MIN_CS_IDLE);
    localparam int TMR_W   = $clog2(max4(HALF_E, SETUP_E, HOLD_E, IDLE_E) + 1);
    localparam int CNT_W   = $clog2(DATA_W + 1);

    // Timer loads are N-1: the zero cycle itself is the last cycle of the phase.
    localparam logic [TMR_W-1:0] LD_SETUP = TMR_W'(SETUP_E - 1);
    localparam logic [TMR_W-1:0] LD_HALF  = TMR_W'(HALF_E - 1);
    localparam logic [TMR_W-1:0] LD_HOLD  = TMR_W'(HOLD_E - 1);
`ifdef SPI_MASTER_BURST_EN
    // CS stays low through the o_done cycle, so GAP is one cycle longer to keep CS_IDLE high.
    localparam logic [TMR_W-1:0] LD_GAP   = TMR_W'(IDLE_E);
`else
    localparam logic [TMR_W-1:0] LD_GAP   = TMR_W'(IDLE_E - 1);
`endif
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);

    logic [2:0]        state;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic              burst_go;

`ifdef SPI_MASTER_BURST_EN
    assign burst_go = o_done & i_start;
`else
    assign burst_go = 1'b0;
`endif

    spi_tick_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            ST_SETUP, ST_SCK_LO: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_HALF;
                end
            end
            ST_SCK_HI: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = (bit_cnt == LAST_BIT) ? LD_HOLD : LD_HALF;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_GAP;
                end
            end
            ST_GAP: begin
                if (burst_go) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_HALF;
                end
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            o_cs      <= 1'b1;
            o_sclk    <= 1'b0;
            o_mosi    <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_rx_data <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state    <= ST_SETUP;
                        tx_shift <= i_tx_data;
                        o_mosi   <= i_tx_data[DATA_W-1];
                        o_cs     <= 1'b0;
                        o_busy   <= 1'b1;
                        bit_cnt  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) state <= ST_SCK_LO;
                end
                ST_SCK_LO: begin
                    if (tmr_zero) begin
                        state    <= ST_SCK_HI;
                        o_sclk   <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], i_miso};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                end
                ST_SCK_HI: begin
                    if (tmr_zero) begin
                        o_sclk <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_HOLD;
                        end else begin
                            state    <= ST_SCK_LO;
                            tx_shift <= tx_shift << 1;
                            o_mosi   <= tx_shift[DATA_W-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        state     <= ST_GAP;
                        o_done    <= 1'b1;
                        o_rx_data <= rx_shift;
`ifndef SPI_MASTER_BURST_EN
                        o_cs      <= 1'b1;
`endif
                    end
                end
                ST_GAP: begin
                    if (burst_go) begin
                        state    <= ST_SCK_LO;
                        tx_shift <= i_tx_data;
                        o_mosi   <= i_tx_data[DATA_W-1];
                        bit_cnt  <= '0;
                    end else begin
                        o_cs <= 1'b1;
                        if (tmr_zero) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_cs   <= 1'b1;
                    o_sclk <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with loopback and mode-0 slave model
`timescale 1ns/1ps
module tb_spi_master;

    localparam int DW       = 16;
    localparam int HALF     = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 4;
    localparam int DONE_LAT = 1 + CS_SETUP + 2 * HALF * DW + CS_HOLD;
    localparam int IDLE_LAT = DONE_LAT + CS_IDLE;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [DW-1:0] i_tx_data = '0;
    logic          i_miso;
    logic          o_busy, o_done, o_cs, o_sclk, o_mosi;
    logic [DW-1:0] o_rx_data;

    logic          loop = 1'b1;
    logic [DW-1:0] slave_word = '0;
    logic [DW-1:0] slv_sh = '0;
    logic [DW-1:0] mosi_cap = '0;
    logic [DW-1:0] done_mosi = '0;
    logic          prev_cs = 1'b1;
    logic          prev_sclk = 1'b0;
    int cyc = 0, pass_cnt = 0, chk_cnt = 0;
    int done_cnt = 0, done_cyc = 0, done_rises = 0, rise_cnt = 0;
    int cs_rises = 0, cs_rise_cyc = 0, last_gap = 0;
    logic [DW-1:0] exp_q[$];

    assign i_miso = loop ? o_mosi : slv_sh[DW-1];

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    spi_master #(
        .DATA_W(DW), .HALF(HALF), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_tx_data(i_tx_data),
        .o_busy(o_busy), .o_done(o_done), .o_rx_data(o_rx_data),
        .o_cs(o_cs), .o_sclk(o_sclk), .o_mosi(o_mosi), .i_miso(i_miso)
    );

    // Monitor and slave model run on the falling edge, away from DUT updates.
    always @(negedge i_clk) begin
        prev_cs   <= o_cs;
        prev_sclk <= o_sclk;
        if (prev_cs && !o_cs) begin
            slv_sh   <= slave_word;
            rise_cnt <= 0;
            mosi_cap <= '0;
            last_gap <= cyc - cs_rise_cyc;
        end else begin
            if (!prev_sclk && o_sclk) begin
                rise_cnt <= rise_cnt + 1;
                mosi_cap <= {mosi_cap[DW-2:0], o_mosi};
            end
            if (prev_sclk && !o_sclk) slv_sh <= {slv_sh[DW-2:0], 1'b0};
        end
        if (!prev_cs && o_cs) begin
            cs_rises    <= cs_rises + 1;
            cs_rise_cyc <= cyc;
        end
        if (o_done) begin
            done_cnt   <= done_cnt + 1;
            done_cyc   <= cyc;
            done_mosi  <= mosi_cap;
            done_rises <= rise_cnt;
        end
    end

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    task automatic start_frame(input logic [DW-1:0] d, input logic [DW-1:0] rx_exp, input bit push, output int acc);
        i_start   = 1'b1;
        i_tx_data = d;
        acc       = cyc;
        if (push) exp_q.push_back(rx_exp);
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int base;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt != base) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit seen, output int at);
        seen = 1'b0;
        at   = cyc;
        for (int i = 0; i < budget; i++) begin
            if (!o_busy) begin
                seen = 1'b1;
                at   = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) step();
        chk_cnt++; if (o_cs !== 1'b1) $display("FAIL reset_cs got %b want 1", o_cs); else pass_cnt++;
        chk_cnt++; if (o_sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", o_sclk); else pass_cnt++;
        chk_cnt++; if (o_mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", o_mosi); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else pass_cnt++;
        chk_cnt++; if (o_done !== 1'b0) $display("FAIL reset_done got %b want 0", o_done); else pass_cnt++;
        chk_cnt++; if (o_rx_data !== '0) $display("FAIL reset_rx got %h want 0000", o_rx_data); else pass_cnt++;
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_loopback();
        int acc, at;
        bit seen;
        logic [DW-1:0] exp;
        loop = 1'b1;
        start_frame(16'hF001, 16'hF001, 1'b1, acc);
        wait_done(400, seen);
        chk_cnt++; if (seen !== 1'b1) $display("FAIL loop_done_timeout got %b want 1", seen); else pass_cnt++;
        if (seen) begin
            exp = exp_q.pop_front();
            chk_cnt++; if (o_rx_data !== exp) $display("FAIL loop_rx got %h want %h", o_rx_data, exp); else pass_cnt++;
            chk_cnt++; if (done_cyc - acc !== DONE_LAT) $display("FAIL loop_done_lat got %0d want %0d", done_cyc - acc, DONE_LAT); else pass_cnt++;
            chk_cnt++; if (done_mosi !== 16'hF001) $display("FAIL loop_mosi_seq got %h want f001", done_mosi); else pass_cnt++;
            chk_cnt++; if (done_rises !== DW) $display("FAIL loop_rises got %0d want %0d", done_rises, DW); else pass_cnt++;
            chk_cnt++; if (o_busy !== 1'b1) $display("FAIL loop_busy_at_done got %b want 1", o_busy); else pass_cnt++;
        end
        wait_idle(100, seen, at);
        chk_cnt++; if (seen !== 1'b1) $display("FAIL loop_idle_timeout got %b want 1", seen); else pass_cnt++;
        chk_cnt++; if (at - acc !== IDLE_LAT) $display("FAIL loop_busy_fall got %0d want %0d", at - acc, IDLE_LAT); else pass_cnt++;
        chk_cnt++; if (o_cs !== 1'b1) $display("FAIL loop_cs_idle got %b want 1", o_cs); else pass_cnt++;
    endtask

    task automatic test_slave();
        int acc, at;
        bit seen;
        logic [DW-1:0] exp;
        loop = 1'b0;
        slave_word = 16'h07CB;
        start_frame(16'h0000, 16'h07CB, 1'b1, acc);
        wait_done(400, seen);
        chk_cnt++; if (seen !== 1'b1) $display("FAIL slave_done_timeout got %b want 1", seen); else pass_cnt++;
        if (seen) begin
            exp = exp_q.pop_front();
            chk_cnt++; if (o_rx_data !== exp) $display("FAIL slave_rx got %h want %h", o_rx_data, exp); else pass_cnt++;
            chk_cnt++; if (done_rises !== DW) $display("FAIL slave_rises got %0d want %0d", done_rises, DW); else pass_cnt++;
            chk_cnt++; if (done_mosi !== 16'h0000) $display("FAIL slave_mosi got %h want 0000", done_mosi); else pass_cnt++;
        end
        wait_idle(100, seen, at);
        loop = 1'b1;
    endtask

    task automatic test_ignore_start();
        int acc, at, base;
        bit seen;
        logic [DW-1:0] exp;
        base = done_cnt;
        start_frame(16'h3C5A, 16'h3C5A, 1'b1, acc);
        while (cyc < acc + 10) step();
        i_start = 1'b1; i_tx_data = 16'hFFFF; step(); i_start = 1'b0;
        while (cyc < acc + 60) step();
        i_start = 1'b1; i_tx_data = 16'h0F0F; step(); i_start = 1'b0;
        wait_done(400, seen);
        chk_cnt++; if (seen !== 1'b1) $display("FAIL ign_done_timeout got %b want 1", seen); else pass_cnt++;
        if (seen) begin
            exp = exp_q.pop_front();
            chk_cnt++; if (o_rx_data !== exp) $display("FAIL ign_rx got %h want %h", o_rx_data, exp); else pass_cnt++;
            chk_cnt++; if (done_mosi !== 16'h3C5A) $display("FAIL ign_mosi got %h want 3c5a", done_mosi); else pass_cnt++;
            chk_cnt++; if (done_cyc - acc !== DONE_LAT) $display("FAIL ign_done_lat got %0d want %0d", done_cyc - acc, DONE_LAT); else pass_cnt++;
        end
        wait_idle(100, seen, at);
        repeat (200) step();
        chk_cnt++; if (done_cnt - base !== 1) $display("FAIL ign_done_count got %0d want 1", done_cnt - base); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL ign_no_queue got %b want 0", o_busy); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int acc, at, base;
        bit seen;
        logic [DW-1:0] exp;
        base = done_cnt;
        start_frame(16'h1234, 16'h0000, 1'b0, acc);
        while (cyc < acc + 50) step();
        i_rst = 1'b1;
        step();
        chk_cnt++; if (o_cs !== 1'b1) $display("FAIL mrst_cs got %b want 1", o_cs); else pass_cnt++;
        chk_cnt++; if (o_sclk !== 1'b0) $display("FAIL mrst_sclk got %b want 0", o_sclk); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", o_busy); else pass_cnt++;
        i_rst = 1'b0;
        repeat (200) step();
        chk_cnt++; if (done_cnt !== base) $display("FAIL mrst_no_done got %0d want %0d", done_cnt, base); else pass_cnt++;
        start_frame(16'h8421, 16'h8421, 1'b1, acc);
        wait_done(400, seen);
        chk_cnt++; if (seen !== 1'b1) $display("FAIL mrst_next_timeout got %b want 1", seen); else pass_cnt++;
        if (seen) begin
            exp = exp_q.pop_front();
            chk_cnt++; if (o_rx_data !== exp) $display("FAIL mrst_next_rx got %h want %h", o_rx_data, exp); else pass_cnt++;
            chk_cnt++; if (done_cyc - acc !== DONE_LAT) $display("FAIL mrst_next_lat got %0d want %0d", done_cyc - acc, DONE_LAT); else pass_cnt++;
        end
        wait_idle(100, seen, at);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [4];
        logic [DW-1:0] exp;
        int acc, at, base;
        bit seen;
        words = '{16'hA177, 16'h0000, 16'hFFFF, 16'h5A5A};
        base = done_cnt;
`ifdef SPI_MASTER_BURST_EN
        begin
            int rises_ref;
            rises_ref = cs_rises;
            start_frame(words[0], words[0], 1'b1, acc);
            for (int k = 0; k < 4; k++) begin
                wait_done(400, seen);
                chk_cnt++; if (seen !== 1'b1) $display("FAIL burst_done_timeout k=%0d got %b want 1", k, seen); else pass_cnt++;
                if (!seen) break;
                exp = exp_q.pop_front();
                chk_cnt++; if (o_rx_data !== exp) $display("FAIL burst_rx k=%0d got %h want %h", k, o_rx_data, exp); else pass_cnt++;
                chk_cnt++; if (done_mosi !== words[k]) $display("FAIL burst_mosi k=%0d got %h want %h", k, done_mosi, words[k]); else pass_cnt++;
                chk_cnt++; if (cs_rises !== rises_ref) $display("FAIL burst_cs_rise k=%0d got %0d want %0d", k, cs_rises, rises_ref); else pass_cnt++;
                if (k < 3) begin
                    i_start = 1'b1; i_tx_data = words[k+1]; exp_q.push_back(words[k+1]);
                    step();
                    i_start = 1'b0;
                end
            end
            chk_cnt++; if (done_rises !== 4 * DW) $display("FAIL burst_total_rises got %0d want %0d", done_rises, 4 * DW); else pass_cnt++;
            chk_cnt++; if (done_cnt - base !== 4) $display("FAIL burst_done_count got %0d want 4", done_cnt - base); else pass_cnt++;
            wait_idle(100, seen, at);
        end
`else
        start_frame(words[0], words[0], 1'b1, acc);
        wait_done(400, seen);
        chk_cnt++; if (seen !== 1'b1) $display("FAIL b2b_first_timeout got %b want 1", seen); else pass_cnt++;
        if (seen) begin
            exp = exp_q.pop_front();
            chk_cnt++; if (o_rx_data !== exp) $display("FAIL b2b_first_rx got %h want %h", o_rx_data, exp); else pass_cnt++;
        end
        i_start = 1'b1; i_tx_data = words[1]; step(); i_start = 1'b0;
        wait_idle(100, seen, at);
        repeat (200) step();
        chk_cnt++; if (done_cnt - base !== 1) $display("FAIL b2b_only_first got %0d want 1", done_cnt - base); else pass_cnt++;
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL b2b_not_accepted got %b want 0", o_busy); else pass_cnt++;
        for (int k = 1; k < 4; k++) begin
            start_frame(words[k], words[k], 1'b1, acc);
            wait_done(400, seen);
            chk_cnt++; if (seen !== 1'b1) $display("FAIL b2b_timeout k=%0d got %b want 1", k, seen); else pass_cnt++;
            if (!seen) break;
            exp = exp_q.pop_front();
            chk_cnt++; if (o_rx_data !== exp) $display("FAIL b2b_rx k=%0d got %h want %h", k, o_rx_data, exp); else pass_cnt++;
            chk_cnt++; if (last_gap < CS_IDLE) $display("FAIL b2b_cs_gap k=%0d got %0d want >=%0d", k, last_gap, CS_IDLE); else pass_cnt++;
            wait_idle(100, seen, at);
            // Re-issue immediately on idle so the CS-high gap is at its minimum.
        end
`endif
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        chk_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
